// File: rtl/isp_frame_sequencer_if.sv
// Host and stage-handshake signals of the per-frame sequencer, grouped as one bundle.
// slave = the sequencer itself, master = the host/datapath side driving it.
interface isp_frame_sequencer_if #(
    parameter int X_MAX      = 200,
    parameter int Y_MAX      = 200,
    parameter int MAX_KERNEL = 3
);
    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(Y_MAX);
    localparam int KW = $clog2(MAX_KERNEL);

    logic          start;
    logic          abort;
    logic [XW-1:0] cfg_max_x;
    logic [YW-1:0] cfg_max_y;
    logic [2:0]    cfg_sigma;
    logic [KW-1:0] cfg_kernel_size;
    logic          cfg_fast_en;

    logic          conv_new_trans;
    logic [XW-1:0] conv_max_x;
    logic [YW-1:0] conv_max_y;
    logic [2:0]    conv_sigma;
    logic [KW-1:0] conv_kernel_size;
    logic          conv_done;
    logic          fast_start;
    logic          fast_done;

    logic          busy;
    logic          frame_done;
    logic          err_cfg;
    logic          err_timeout;
    logic [7:0]    frame_count;
    logic [2:0]    state;

    modport slave (
        input  start, abort, cfg_max_x, cfg_max_y, cfg_sigma, cfg_kernel_size, cfg_fast_en,
        input  conv_done, fast_done,
        output conv_new_trans, conv_max_x, conv_max_y, conv_sigma, conv_kernel_size,
        output fast_start, busy, frame_done, err_cfg, err_timeout, frame_count, state
    );

    modport master (
        output start, abort, cfg_max_x, cfg_max_y, cfg_sigma, cfg_kernel_size, cfg_fast_en,
        output conv_done, fast_done,
        input  conv_new_trans, conv_max_x, conv_max_y, conv_sigma, conv_kernel_size,
        input  fast_start, busy, frame_done, err_cfg, err_timeout, frame_count, state
    );
endinterface

// File: rtl/isp_frame_sequencer.sv
// Per-frame controller: validates a host start, latches the frame config, then runs the
// blur stage and optionally the detect stage, each wait guarded by a watchdog.
module isp_frame_sequencer #(
    parameter int X_MAX          = 200,
    parameter int Y_MAX          = 200,
    parameter int MAX_KERNEL     = 3,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                   clk,
    input  logic                   n_rst,
    isp_frame_sequencer_if.slave   ctrl
);
    localparam int XW  = $clog2(X_MAX);
    localparam int YW  = $clog2(Y_MAX);
    localparam int KW  = $clog2(MAX_KERNEL);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_BLUR_START = 3'd1,
        S_BLUR_WAIT  = 3'd2,
        S_DET_START  = 3'd3,
        S_DET_WAIT   = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t        state_reg, state_next;
    logic [XW-1:0] conv_max_x_reg, conv_max_x_next;
    logic [YW-1:0] conv_max_y_reg, conv_max_y_next;
    logic [2:0]    conv_sigma_reg, conv_sigma_next;
    logic [KW-1:0] conv_kernel_size_reg, conv_kernel_size_next;
    logic          fast_en_reg, fast_en_next;
    logic          err_cfg_reg, err_cfg_next;
    logic          err_timeout_reg, err_timeout_next;
    logic [7:0]    frame_count_reg, frame_count_next;
    logic [WDW-1:0] wd_reg, wd_next;

    logic cfg_valid;
    logic wd_expired;

    assign cfg_valid = (ctrl.cfg_max_x != '0) && (ctrl.cfg_max_y != '0) &&
                       ctrl.cfg_kernel_size[0] &&
                       (int'(ctrl.cfg_kernel_size) <= MAX_KERNEL) &&
                       (ctrl.cfg_sigma != 3'd0);

    // Expires on the last allowed WAIT cycle; a done in that same cycle still wins.
    assign wd_expired = (wd_reg == WDW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next            = state_reg;
        conv_max_x_next       = conv_max_x_reg;
        conv_max_y_next       = conv_max_y_reg;
        conv_sigma_next       = conv_sigma_reg;
        conv_kernel_size_next = conv_kernel_size_reg;
        fast_en_next          = fast_en_reg;
        err_cfg_next          = err_cfg_reg;
        err_timeout_next      = err_timeout_reg;
        frame_count_next      = frame_count_reg;
        wd_next               = '0;

        if (ctrl.abort) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (ctrl.start) begin
                        if (cfg_valid) begin
                            conv_max_x_next       = ctrl.cfg_max_x;
                            conv_max_y_next       = ctrl.cfg_max_y;
                            conv_sigma_next       = ctrl.cfg_sigma;
                            conv_kernel_size_next = ctrl.cfg_kernel_size;
                            fast_en_next          = ctrl.cfg_fast_en;
                            err_cfg_next          = 1'b0;
                            err_timeout_next      = 1'b0;
                            state_next            = S_BLUR_START;
                        end else begin
                            err_cfg_next = 1'b1;
                        end
                    end
                end
                S_BLUR_START: state_next = S_BLUR_WAIT;
                S_BLUR_WAIT: begin
                    if (ctrl.conv_done) begin
                        if (fast_en_reg) begin
                            state_next = S_DET_START;
                        end else begin
                            state_next       = S_DONE;
                            frame_count_next = frame_count_reg + 8'd1;
                        end
                    end else if (wd_expired) begin
                        err_timeout_next = 1'b1;
                        state_next       = S_IDLE;
                    end else begin
                        wd_next = wd_reg + WDW'(1);
                    end
                end
                S_DET_START: state_next = S_DET_WAIT;
                S_DET_WAIT: begin
                    if (ctrl.fast_done) begin
                        state_next       = S_DONE;
                        frame_count_next = frame_count_reg + 8'd1;
                    end else if (wd_expired) begin
                        err_timeout_next = 1'b1;
                        state_next       = S_IDLE;
                    end else begin
                        wd_next = wd_reg + WDW'(1);
                    end
                end
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg            <= S_IDLE;
            conv_max_x_reg       <= '0;
            conv_max_y_reg       <= '0;
            conv_sigma_reg       <= '0;
            conv_kernel_size_reg <= '0;
            fast_en_reg          <= 1'b0;
            err_cfg_reg          <= 1'b0;
            err_timeout_reg      <= 1'b0;
            frame_count_reg      <= '0;
            wd_reg               <= '0;
        end else begin
            state_reg            <= state_next;
            conv_max_x_reg       <= conv_max_x_next;
            conv_max_y_reg       <= conv_max_y_next;
            conv_sigma_reg       <= conv_sigma_next;
            conv_kernel_size_reg <= conv_kernel_size_next;
            fast_en_reg          <= fast_en_next;
            err_cfg_reg          <= err_cfg_next;
            err_timeout_reg      <= err_timeout_next;
            frame_count_reg      <= frame_count_next;
            wd_reg               <= wd_next;
        end
    end

    // Every output comes straight from a register or a decode of the state register.
    assign ctrl.state            = state_reg;
    assign ctrl.busy             = (state_reg != S_IDLE);
    assign ctrl.conv_new_trans   = (state_reg == S_BLUR_START);
    assign ctrl.fast_start       = (state_reg == S_DET_START);
    assign ctrl.frame_done       = (state_reg == S_DONE);
    assign ctrl.conv_max_x       = conv_max_x_reg;
    assign ctrl.conv_max_y       = conv_max_y_reg;
    assign ctrl.conv_sigma       = conv_sigma_reg;
    assign ctrl.conv_kernel_size = conv_kernel_size_reg;
    assign ctrl.err_cfg          = err_cfg_reg;
    assign ctrl.err_timeout      = err_timeout_reg;
    assign ctrl.frame_count      = frame_count_reg;
endmodule
